// File: rtl/prog_ram_pkg.sv
// prog_ram_pkg: shared definitions for the program-memory controller.
//   state_t     - controller FSM state, also exported on the debug port
//   DEF_DATA_W  - default instruction word width
//   DEF_ADDR_W  - default address width (depth = 2**ADDR_W)
package prog_ram_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURN   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/prog_ram_core.sv
// prog_ram_core: single-port inferred RAM, DATA_W x 2**ADDR_W, registered read.
//   clk   - clock
//   addr  - shared read/write address
//   we    - write enable (wdata -> mem[addr]); wins over re
//   wdata - write data
//   re    - read enable; rdata updates on the next edge, otherwise holds
//   rdata - registered read data
module prog_ram_core
  import prog_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // No reset on the array or read register: program contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/prog_ram_ctrl.sv
// prog_ram_ctrl: program RAM with a sequential burn (load) engine and CPU fetch port.
//   clk, rst         - clock, synchronous active-high reset
//   burn_start       - pulse in IDLE: latch burn_base/burn_len and start a burn
//   burn_base        - first write address
//   burn_len         - word count, legal 1..DEPTH; otherwise burn_err and no write
//   burn_valid/data  - write stream; burn_ready is the registered accept
//   burn_done        - one-cycle pulse at end of burn (success or error)
//   burn_err         - sticky error, cleared by the next accepted burn_start
//   busy             - state != IDLE
//   fetch_en/addr    - CPU read, served only in IDLE, one-cycle latency
//   fetch_data/valid - read data; holds its last value when no fetch returns
//   state            - debug view of the controller FSM
// Optional build macro PROG_RAM_VERIFY_EN adds a read-back XOR checksum pass
// (VERIFY state) between the last write and DONE.
//
// Handshake: a burn word transfers on every rising edge where state is BURN
// and burn_valid && burn_ready; burn_data is ignored on all other edges.
module prog_ram_ctrl
  import prog_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              burn_start,
  input  logic [ADDR_W-1:0] burn_base,
  input  logic [ADDR_W:0]   burn_len,
  input  logic              burn_valid,
  input  logic [DATA_W-1:0] burn_data,
  output logic              burn_ready,
  output logic              burn_done,
  output logic              burn_err,
  output logic              busy,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output state_t            state
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W+1:0] cnt;       // words accepted in BURN, verify step in VERIFY
  logic [ADDR_W+1:0] cnt_inc;
  logic [ADDR_W+1:0] len_ext;
  logic [ADDR_W-1:0] wr_addr;   // write pointer in BURN, read pointer in VERIFY
  logic [DATA_W-1:0] fetch_hold;
  logic [DATA_W-1:0] ram_rdata;
  logic              accept;
  logic              last_word;
  logic              fetch_go;
  logic              rd_go;
  logic              len_bad;

  assign cnt_inc   = cnt + 1'b1;
  assign len_ext   = {1'b0, len_q};
  assign accept    = (state == BURN) && burn_valid && burn_ready;
  assign last_word = accept && (cnt_inc == len_ext);
  assign fetch_go  = (state == IDLE) && fetch_en;
  assign len_bad   = (burn_len == '0) || (burn_len > DEPTH);
  assign busy      = (state != IDLE);

`ifdef PROG_RAM_VERIFY_EN
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] csum_w;
  logic [DATA_W-1:0] csum_r;
  // Reads are issued on the first len VERIFY cycles; data lands one cycle later.
  assign rd_go = (state == VERIFY) && (cnt < len_ext);
`else
  assign rd_go = 1'b0;
`endif

  // Only IDLE uses the fetch address; BURN and VERIFY walk wr_addr.
  prog_ram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
    .clk   (clk),
    .addr  ((state == IDLE) ? fetch_addr : wr_addr),
    .we    (accept),
    .wdata (burn_data),
    .re    (fetch_go || rd_go),
    .rdata (ram_rdata)
  );

  // RAM read register is shared with verify, so a copy of the last fetch is
  // kept and shown whenever no fetch is returning.
  assign fetch_data = fetch_valid ? ram_rdata : fetch_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      burn_ready  <= 1'b0;
      burn_done   <= 1'b0;
      burn_err    <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_hold  <= '0;
      len_q       <= '0;
      cnt         <= '0;
      wr_addr     <= '0;
`ifdef PROG_RAM_VERIFY_EN
      base_q      <= '0;
      csum_w      <= '0;
      csum_r      <= '0;
`endif
    end else begin
      burn_done   <= 1'b0;
      fetch_valid <= fetch_go;
      if (fetch_valid) fetch_hold <= ram_rdata;
      case (state)
        IDLE: begin
          if (burn_start) begin
            len_q   <= burn_len;
            wr_addr <= burn_base;
            cnt     <= '0;
`ifdef PROG_RAM_VERIFY_EN
            base_q  <= burn_base;
            csum_w  <= '0;
            csum_r  <= '0;
`endif
            if (len_bad) begin
              burn_err  <= 1'b1;
              burn_done <= 1'b1;
              state     <= DONE;
            end else begin
              burn_err   <= 1'b0;
              burn_ready <= 1'b1;
              state      <= BURN;
            end
          end
        end
        BURN: begin
          if (accept) begin
            wr_addr <= wr_addr + 1'b1;   // wraps modulo DEPTH
            cnt     <= cnt_inc;
`ifdef PROG_RAM_VERIFY_EN
            csum_w  <= csum_w ^ burn_data;
`endif
          end
          if (last_word) begin
            burn_ready <= 1'b0;
`ifdef PROG_RAM_VERIFY_EN
            state   <= VERIFY;
            cnt     <= '0;
            wr_addr <= base_q;
`else
            burn_done <= 1'b1;
            state     <= DONE;
`endif
          end
        end
`ifdef PROG_RAM_VERIFY_EN
        VERIFY: begin
          cnt <= cnt_inc;
          if (rd_go) wr_addr <= wr_addr + 1'b1;
          if ((cnt != '0) && (cnt <= len_ext)) csum_r <= csum_r ^ ram_rdata;
          // len+2 VERIFY cycles: len reads, last data accumulate, compare.
          if (cnt == len_ext + 1'b1) begin
            if (csum_r != csum_w) burn_err <= 1'b1;
            burn_done <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_ram_ctrl.md
# prog_ram_ctrl

Parametrised program-memory controller for the CPU: owns the instruction RAM and adds a sequential burn (load) engine with a valid/ready stream, auto-incrementing address, length control and error reporting. The CPU fetch port reads with fixed one-cycle latency when no burn is active. It is the next generation of the bare program RAM: a generic width and depth, plus a loader FSM and an optional read-back verification pass.

## Interface
- DATA_W, 16, instruction word width
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- burn_start  in  1  one-cycle pulse; latches burn_base/burn_len, starts burn
- burn_base  in  ADDR_W  first write address
- burn_len  in  ADDR_W+1  word count, legal 1..DEPTH
- burn_valid  in  1  burn_data valid
- burn_data  in  DATA_W  word to write
- burn_ready  out  1  controller accepts burn_data
- burn_done  out  1  one-cycle pulse at end of burn (success or error)
- burn_err  out  1  sticky error, cleared by next accepted burn_start or rst
- busy  out  1  high in any state other than IDLE
- fetch_en  in  1  CPU read request
- fetch_addr  in  ADDR_W  CPU read address
- fetch_data  out  DATA_W  registered read data
- fetch_valid  out  1  fetch_data valid this cycle

## Operation
- States: IDLE, BURN, VERIFY (only with the macro), DONE.
- IDLE: burn_start=1 latches base/len, clears burn_err and the word counter, and moves to BURN. If burn_len==0 or burn_len>DEPTH, it instead sets burn_err, moves to DONE, and writes nothing.
- BURN: burn_ready=1. Each cycle with burn_valid&&burn_ready writes burn_data to wr_addr, increments wr_addr modulo DEPTH (base+len past the top wraps to 0) and increments the counter. When the counter reaches len, moves to DONE (or VERIFY) on the same edge.
- DONE: burn_done=1 for one cycle, then IDLE.
- burn_start while busy is ignored. burn_valid outside BURN is ignored.
- Fetch is served only in IDLE: fetch_en=1 reads mem[fetch_addr]. Fetch in any other state is dropped: fetch_valid=0 and fetch_data holds its last value.
- If burn_start and fetch_en arrive in the same IDLE cycle, the fetch is served and the burn starts.
- rst mid-burn: goes to IDLE and clears all outputs. Words already written are retained; memory is never cleared by reset.

## Timing
- Reset values: burn_ready=0, burn_done=0, burn_err=0, busy=0, fetch_data=0, fetch_valid=0, state=IDLE.
- Write latency: a word accepted at edge N is readable by a fetch issued at edge N+1 or later.
- Fetch latency: fetch_en at edge N gives fetch_valid=1 and fetch_data for the cycle after edge N. Back-to-back fetches are supported at one per cycle.
- burn_ready is registered. It is 1 from the cycle after burn_start until the cycle after the last accepted word.
- burn_done rises exactly one cycle after the last write (no macro), or one cycle after the final verify compare.

## Configuration
- PROG_RAM_VERIFY_EN defined:
  - BURN accumulates an XOR checksum of the accepted words.
  - After the last write, VERIFY reads back len words from base (same wrap rule), one per cycle, and XOR-accumulates them.
  - One cycle after the last read data returns, the two checksums are compared; a mismatch sets burn_err. Then DONE.
  - Verify adds len+2 cycles. Fetch is blocked throughout.
- PROG_RAM_VERIFY_EN undefined: there is no VERIFY state and no checksum logic, and BURN goes directly to DONE.

## Structure
- Shared package prog_ram_pkg: state enum (IDLE, BURN, VERIFY, DONE) and default DATA_W/ADDR_W constants.
- Sub-module prog_ram_core: single-port inferred RAM (DATA_W x DEPTH) with registered read. The controller muxes its address/wren/rden between burn, verify and fetch.

## Test plan
- Burn len=3 at base 0 with 0x2309, 0x9C00, 0xC000; then fetch addresses 0, 1, 2 back-to-back -> fetch_valid on three consecutive cycles with 0x2309, 0x9C00, 0xC000; burn_done pulses once; burn_err=0.
- burn_len=0 -> burn_done pulses 1 cycle after start, burn_err=1, no write (fetch addr 0 returns the prior contents). Repeat with burn_len=DEPTH+1 -> same response.
- Base 0xFE, len=4, data 1..4 -> words at 0xFE, 0xFF, 0x00, 0x01; fetches return 1, 2, 3, 4.
- burn_valid toggled 1010… during BURN -> only the valid cycles write; the counter reaches len only after 3 accepts; fetch_en asserted mid-burn -> fetch_valid stays 0.
- rst asserted after 2 of 4 words -> next cycle all outputs 0 and state IDLE; fetch of the first 2 addresses returns the written data; a new burn_start is accepted.
- With PROG_RAM_VERIFY_EN: a clean burn of len=3 -> burn_done exactly 5 cycles after the last write, burn_err=0. Force one RAM word corrupt between write and read-back -> burn_err=1.
